// File: rtl/secuenciador_pc.sv
// secuenciador_pc: program-counter sequencer for the MIPS fetch stage.
// Holds the PC, offers it to instruction memory under valid/ready, forms
// branch / jump / jump-register targets and buffers one redirect that
// arrives while fetch is blocked (the oldest redirect wins).
module secuenciador_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_ready,
    input  logic        stall,
    input  logic [31:0] redirect_base,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misaligned
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_exc_q, pend_exc_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;

    logic        accept;
    logic        req;
    logic [31:0] req_target;
    logic        req_exc;

    assign fetch_valid = (state_q == RUN);
    assign fetch_addr  = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign flush       = flush_q;
    assign misaligned  = misaligned_q;
    assign accept      = fetch_valid & fetch_ready & ~stall;

    // Select the winning redirect request (jump_reg > jump > branch) and its target.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        req        = 1'b0;
        req_target = 32'h0;
        req_exc    = 1'b0;
        if (jump_reg) begin
            req = 1'b1;
            if (reg_target[1:0] != 2'b00) begin
                req_target = EXC_VECTOR;
                req_exc    = 1'b1;
            end else begin
                req_target = reg_target;
            end
        end else if (jump) begin
            req        = 1'b1;
            req_target = {redirect_base[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            req        = 1'b1;
            req_target = redirect_base + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        end
    end

    // Next-state: boot sequencing, PC update on accept, pending-buffer capture, pulse outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        flush_d       = 1'b0;
        misaligned_d  = 1'b0;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (accept) begin
            if (pend_valid_q) begin
                // A buffered redirect is older than anything arriving now.
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
                flush_d      = 1'b1;
                misaligned_d = pend_exc_q;
            end else if (req) begin
                pc_d         = req_target;
                flush_d      = 1'b1;
                misaligned_d = req_exc;
            end else begin
                pc_d = pc_plus4;
            end
        end else if (req && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = req_target;
            pend_exc_d    = req_exc;
        end
    end

    // State registers; reset discards any pending redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            pend_exc_q    <= 1'b0;
            flush_q       <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
            flush_q       <= flush_d;
            misaligned_q  <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_secuenciador_pc.sv
// Testbench for secuenciador_pc: directed vector table, hand-written reset
// corner case, then randomized stimulus against a behavioural model.
module tb_secuenciador_pc;

    localparam logic [31:0] EXC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_ready, stall, branch_taken, jump, jump_reg;
    logic [31:0] redirect_base, reg_target;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic        fetch_valid, flush, misaligned;
    logic [31:0] fetch_addr, pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    secuenciador_pc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_ready  (fetch_ready),
        .stall        (stall),
        .redirect_base(redirect_base),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .fetch_valid  (fetch_valid),
        .fetch_addr   (fetch_addr),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    // One directed step: inputs for this cycle plus outputs expected before the edge.
    typedef struct {
        logic        rdy, stl;
        logic [31:0] base;
        logic        br;
        logic [15:0] off;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] rt;
        logic [31:0] e_addr;
        logic        e_valid, e_flush, e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] target;
        bit          exc;
    } pend_t;

    vec_t tbl[24];

    // Behavioural model state.
    logic [31:0] m_pc;
    bit          m_valid, m_flush, m_mis;
    pend_t       m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic [31:0] base,
                         input logic br, input logic [15:0] off, input logic j,
                         input logic [25:0] idx, input logic jr, input logic [31:0] rt);
        fetch_ready   = rdy;
        stall         = stl;
        redirect_base = base;
        branch_taken  = br;
        branch_offset = off;
        jump          = j;
        jump_index    = idx;
        jump_reg      = jr;
        reg_target    = rt;
    endtask

    task automatic idle(input logic rdy, input logic stl);
        drive(rdy, stl, 32'h0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    function automatic vec_t mk(input logic rdy, input logic stl, input logic [31:0] base,
                                input logic br, input logic [15:0] off, input logic j,
                                input logic [25:0] idx, input logic jr, input logic [31:0] rt,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic e_flush, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.base = base; v.br = br; v.off = off;
        v.j = j; v.idx = idx; v.jr = jr; v.rt = rt;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_flush = e_flush; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        idle(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Model: which redirect the current inputs request, from the ISA rules.
    function automatic void model_request(output bit req, output pend_t p);
        int soff;
        req = 1'b1;
        p.exc = 1'b0;
        if (jump_reg) begin
            if (reg_target % 4 != 0) begin
                p.target = EXC;
                p.exc    = 1'b1;
            end else begin
                p.target = reg_target;
            end
        end else if (jump) begin
            p.target = (redirect_base & 32'hF000_0000) | (32'(jump_index) * 4);
        end else if (branch_taken) begin
            soff     = $signed(branch_offset);
            p.target = redirect_base + 32'(soff * 4);
        end else begin
            req      = 1'b0;
            p.target = 32'h0;
        end
    endfunction

    // Check DUT against model, then advance both across one clock edge.
    task automatic model_cycle(input int cyc);
        bit    req, acc;
        pend_t p, head;
        check($sformatf("rnd%0d addr", cyc), fetch_addr, m_pc);
        check($sformatf("rnd%0d valid", cyc), 32'(fetch_valid), 32'(m_valid));
        check($sformatf("rnd%0d flush", cyc), 32'(flush), 32'(m_flush));
        check($sformatf("rnd%0d misaligned", cyc), 32'(misaligned), 32'(m_mis));
        check($sformatf("rnd%0d pc_plus4", cyc), pc_plus4, m_pc + 32'd4);
        model_request(req, p);
        acc     = m_valid && fetch_ready && !stall;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (acc) begin
            if (m_pend.size() != 0) begin
                head    = m_pend.pop_front();
                m_pc    = head.target;
                m_flush = 1'b1;
                m_mis   = head.exc;
            end else if (req) begin
                m_pc    = p.target;
                m_flush = 1'b1;
                m_mis   = p.exc;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (req && m_pend.size() == 0) begin
            m_pend.push_back(p);
        end
        m_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //            rdy stl base          br  off       j   idx          jr  rt             addr          v  f  m
        tbl[0]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0000, 1, 0, 0);
        tbl[2]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0004, 1, 0, 0);
        tbl[3]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0008, 1, 0, 0);
        tbl[4]  = mk(1, 0, 32'hA000_0010,0, 16'h0,    1, 26'h3FF_FFFF,0, 32'h0,         32'h0000_000C, 1, 0, 0);
        tbl[5]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'hAFFF_FFFC, 1, 1, 0);
        tbl[6]  = mk(1, 0, 32'h0000_1000,1, 16'hFFFF, 1, 26'h000_0040,0, 32'h0,         32'hB000_0000, 1, 0, 0);
        tbl[7]  = mk(0, 1, 32'h0000_0200,1, 16'h0004, 0, 26'h0,       0, 32'h0,         32'h0000_0100, 1, 1, 0);
        tbl[8]  = mk(0, 1, 32'h0000_0200,0, 16'h0,    1, 26'h10,      0, 32'h0,         32'h0000_0100, 1, 0, 0);
        tbl[9]  = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0100, 1, 0, 0);
        tbl[10] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       1, 32'h0000_0402, 32'h0000_0210, 1, 1, 0);
        tbl[11] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0080, 1, 1, 1);
        tbl[12] = mk(1, 1, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0084, 1, 0, 0);
        tbl[13] = mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0084, 1, 0, 0);
        tbl[14] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       1, 32'hFFFF_FFFC, 32'h0000_0084, 1, 0, 0);
        tbl[15] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'hFFFF_FFFC, 1, 1, 0);
        tbl[16] = mk(1, 0, 32'h0,        1, 16'h0001, 1, 26'h5,       1, 32'h0000_0300, 32'h0000_0000, 1, 0, 0);
        tbl[17] = mk(0, 0, 32'h0,        0, 16'h0,    0, 26'h0,       1, 32'h0000_0501, 32'h0000_0300, 1, 1, 0);
        tbl[18] = mk(1, 0, 32'h0,        0, 16'h0,    1, 26'h7,       0, 32'h0,         32'h0000_0300, 1, 0, 0);
        tbl[19] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0080, 1, 1, 1);
        tbl[20] = mk(0, 0, 32'h0000_1000,1, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_0084, 1, 0, 0);
        tbl[21] = mk(1, 0, 32'h0,        0, 16'h0,    1, 26'h20,      0, 32'h0,         32'h0000_0084, 1, 0, 0);
        tbl[22] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_1000, 1, 1, 0);
        tbl[23] = mk(1, 0, 32'h0,        0, 16'h0,    0, 26'h0,       0, 32'h0,         32'h0000_1004, 1, 0, 0);

        // ---- Directed table from reset release ----
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rdy, tbl[i].stl, tbl[i].base, tbl[i].br, tbl[i].off,
                  tbl[i].j, tbl[i].idx, tbl[i].jr, tbl[i].rt);
            #1;
            check($sformatf("vec%0d addr", i), fetch_addr, tbl[i].e_addr);
            check($sformatf("vec%0d pc_plus4", i), pc_plus4, tbl[i].e_addr + 32'd4);
            check($sformatf("vec%0d valid", i), 32'(fetch_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d flush", i), 32'(flush), 32'(tbl[i].e_flush));
            check($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(tbl[i].e_mis));
            @(posedge clk);
            @(negedge clk);
        end

        // ---- Mid-run reset with a redirect pending at fetch_addr 0x48 ----
        drive(1, 0, 32'h0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0044);
        @(negedge clk);
        idle(1'b1, 1'b0);
        @(negedge clk);
        check("midrst at 0x48", fetch_addr, 32'h0000_0048);
        drive(0, 0, 32'h0, 1, 16'h0100, 0, 26'h0, 0, 32'h0);
        @(negedge clk);
        idle(1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst async addr", fetch_addr, 32'h0000_0000);
        check("midrst async valid", 32'(fetch_valid), 32'd0);
        check("midrst async flush", 32'(flush), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst boot valid", 32'(fetch_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("midrst restart%0d addr", k), fetch_addr, 32'(k) * 32'd4);
            check($sformatf("midrst restart%0d flush", k), 32'(flush), 32'd0);
        end

        // ---- Randomized run against the behavioural model ----
        apply_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_mis = 1'b0;
        m_pend.delete();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom,
                  $urandom_range(0, 5) == 0, 16'($urandom), $urandom_range(0, 5) == 0,
                  26'($urandom), $urandom_range(0, 6) == 0,
                  ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom);
            #1;
            model_cycle(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
